// File: rtl/add_sub_pkg.sv
// Shared types and sizing helpers for the serial adder/subtractor.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int unsigned calc_nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Slice index width; never below one bit so a single-slice build still has a register.
  function automatic int unsigned calc_idx_w(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice. o_msb_cin is the carry into the
// top bit, used for signed-overflow detection on the most significant slice.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_msb_cin
);

  logic [CHUNK:0] w_c;

  // Ripple the carry from bit 0 upwards.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
    end
  end

  assign o_cout    = w_c[CHUNK];
  assign o_msb_cin = w_c[CHUNK-1];

endmodule

// File: rtl/serial_adder_subtractor.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB slice first, behind a
// start/done handshake. Define ADD_SUB_OVERFLOW_EN to add the signed overflow output.
module serial_adder_subtractor
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef ADD_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDX_W  = calc_idx_w(NCHUNK);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("serial_adder_subtractor: WIDTH must be an integer multiple of CHUNK");
  end

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_op_a, r_op_b, r_part, r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry, r_c_out;
  logic               w_accept, w_last;
  logic [31:0]        w_base;
  logic [CHUNK-1:0]   w_a_slice, w_b_slice, w_s;
  logic               w_cout, w_msb_cin;
  logic [WIDTH-1:0]   w_part_next;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_idx == IDX_W'(NCHUNK - 1));
  assign w_base   = 32'(r_idx) * CHUNK;

  // Select the current operand slices and splice the new slice into the partial result.
  always_comb begin
    w_a_slice   = r_op_a[w_base +: CHUNK];
    w_b_slice   = r_op_b[w_base +: CHUNK];
    w_part_next = r_part;
    w_part_next[w_base +: CHUNK] = w_s;
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .i_a       (w_a_slice),
    .i_b       (w_b_slice),
    .i_cin     (r_carry),
    .o_sum     (w_s),
    .o_cout    (w_cout),
    .o_msb_cin (w_msb_cin)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; DONE accepts a new start exactly like IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = BUSY;
      BUSY:    if (w_last)   w_state_next = DONE;
      DONE:    w_state_next = w_accept ? BUSY : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch, per-slice accumulation and result update on the final slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
    end else if (w_accept) begin
      // Subtract as a + ~b + 1: invert B and seed the carry with M.
      r_op_a  <= a;
      r_op_b  <= b ^ {WIDTH{M}};
      r_carry <= M;
      r_idx   <= '0;
    end else if (r_state == BUSY) begin
      r_part  <= w_part_next;
      r_carry <= w_cout;
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_sum   <= w_part_next;
        r_c_out <= w_cout;
      end
    end
  end

`ifdef ADD_SUB_OVERFLOW_EN
  logic r_overflow;

  // Signed overflow captured alongside sum on the completing edge.
  always_ff @(posedge clk) begin
    if (rst)                                r_overflow <= 1'b0;
    else if ((r_state == BUSY) && w_last)   r_overflow <= w_msb_cin ^ w_cout;
  end

  assign overflow = r_overflow;
`else
  logic w_unused_msb_cin;
  assign w_unused_msb_cin = w_msb_cin;
`endif

  assign busy  = (r_state == BUSY);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed bench for serial_adder_subtractor: default 16/4 build plus a 32/8 instance.
module tb_serial_adder_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, m;
  logic [15:0] a, b, sum;
  logic        busy, done, c_out;
  logic        start32, m32;
  logic [31:0] a32, b32, sum32;
  logic        busy32, done32, c_out32;
`ifdef ADD_SUB_OVERFLOW_EN
  logic        overflow, overflow32;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_subtractor #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .M        (m),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out)
`ifdef ADD_SUB_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  serial_adder_subtractor #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk      (clk),
    .rst      (rst),
    .start    (start32),
    .a        (a32),
    .b        (b32),
    .M        (m32),
    .busy     (busy32),
    .done     (done32),
    .sum      (sum32),
    .c_out    (c_out32)
`ifdef ADD_SUB_OVERFLOW_EN
    ,
    .overflow (overflow32)
`endif
  );

  // Pulse start for one op; edges counts the accepting edge as 1, up to the edge
  // after which done is seen. busy_cycles counts sampled busy=1 cycles.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic im,
                        output int edges, output int busy_cycles);
    @(negedge clk);
    a = ia; b = ib; m = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ia; b = ~ib; m = ~im;  // must not matter once latched
    edges = 1;
    busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; m = 1'b0;
    start32 = 1'b0; a32 = '0; b32 = '0; m32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {busy, done});
    checks++; if (sum !== 16'h0000) $display("FAIL reset_sum: got %h expected 0000", sum);
    checks++; if (c_out !== 1'b0) $display("FAIL reset_cout: got %b expected 0", c_out);
    checks++; if ({busy32, done32, c_out32} !== 3'b000 || sum32 !== 32'h0)
      $display("FAIL reset_dut32: got %b/%h expected 000/00000000", {busy32, done32, c_out32}, sum32);
    rst = 1'b0;
    errors += 0;
  endtask

  task automatic test_add();
    int e, bc;
    run_op(16'd5, 16'd6, 1'b0, e, bc);
    checks++; if (e !== 5) begin errors++; $display("FAIL add_latency: got %0d edges expected 5", e); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL add_busy_cycles: got %0d expected 4", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_in_done: got %b expected 0", busy); end
    checks++; if (sum !== 16'd11 || c_out !== 1'b0) begin
      errors++; $display("FAIL add_5_6: got %h/%b expected 000b/0", sum, c_out); end
`ifdef ADD_SUB_OVERFLOW_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL add_5_6_ovf: got %b expected 0", overflow); end
`endif
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL done_one_cycle: got %b expected 00", {busy, done}); end
    checks++; if (sum !== 16'd11) begin errors++; $display("FAIL sum_hold: got %h expected 000b", sum); end
  endtask

  task automatic test_sub();
    int e, bc;
    run_op(16'd6, 16'd4, 1'b1, e, bc);
    checks++; if (sum !== 16'h0002 || c_out !== 1'b1) begin
      errors++; $display("FAIL sub_6_4: got %h/%b expected 0002/1", sum, c_out); end
    run_op(16'd6, 16'd7, 1'b1, e, bc);
    checks++; if (sum !== 16'hFFFF || c_out !== 1'b0) begin
      errors++; $display("FAIL sub_6_7: got %h/%b expected ffff/0", sum, c_out); end
`ifdef ADD_SUB_OVERFLOW_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub_6_7_ovf: got %b expected 0", overflow); end
`endif
  endtask

  task automatic test_carry_chain();
    int e, bc;
    run_op(16'hFFFF, 16'h0001, 1'b0, e, bc);
    checks++; if (sum !== 16'h0000 || c_out !== 1'b1) begin
      errors++; $display("FAIL carry_chain: got %h/%b expected 0000/1", sum, c_out); end
`ifdef ADD_SUB_OVERFLOW_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL carry_chain_ovf: got %b expected 0", overflow); end
    run_op(16'h7FFF, 16'h0001, 1'b0, e, bc);
    checks++; if (sum !== 16'h8000 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_7fff_1: got %h/%b expected 8000/1", sum, overflow); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] opa [3] = '{16'h1234, 16'h1000, 16'h8000};
    logic [15:0] opb [3] = '{16'h1111, 16'h0001, 16'h8000};
    logic        opm [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] exp_s [3] = '{16'h2345, 16'h0FFF, 16'h0000};
    logic        exp_c [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] prev;
    int          e;
    logic        stable;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      prev = sum;
      a = opa[i]; b = opb[i]; m = opm[i]; start = 1'b1;
      @(posedge clk); #1;
      a = 16'hAAAA; b = 16'h5555; m = ~opm[i];  // start stays high; busy ignores it
      e = 1;
      stable = 1'b1;
      while (!done && e < 40) begin
        if (sum !== prev) stable = 1'b0;
        @(posedge clk); #1;
        e++;
      end
      checks++; if (e !== 5) begin errors++; $display("FAIL b2b_period%0d: got %0d expected 5", i, e); end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL b2b_hold%0d: got %b expected 1", i, stable); end
      checks++; if (sum !== exp_s[i] || c_out !== exp_c[i]) begin
        errors++; $display("FAIL b2b_result%0d: got %h/%b expected %h/%b", i, sum, c_out, exp_s[i], exp_c[i]); end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_mid_reset();
    int e, bc;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; m = 1'b0; start = 1'b1;
    @(posedge clk); #1;            // E0: first BUSY cycle
    start = 1'b0;
    @(posedge clk); #1;            // E1: second BUSY cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL midrst_flags: got %b expected 00", {busy, done}); end
    checks++; if (sum !== 16'h0000 || c_out !== 1'b0) begin
      errors++; $display("FAIL midrst_result: got %h/%b expected 0000/0", sum, c_out); end
    run_op(16'd7, 16'd8, 1'b0, e, bc);
    checks++; if (e !== 5 || sum !== 16'd15 || c_out !== 1'b0) begin
      errors++; $display("FAIL midrst_recover: got %0d/%h/%b expected 5/000f/0", e, sum, c_out); end
  endtask

  task automatic test_wide();
    int e;
    @(negedge clk);
    a32 = 32'h0; b32 = 32'h1; m32 = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; b32 = 32'h0;
    e = 1;
    while (!done32 && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    checks++; if (e !== 5) begin errors++; $display("FAIL wide_latency: got %0d expected 5", e); end
    checks++; if (sum32 !== 32'hFFFF_FFFF || c_out32 !== 1'b0) begin
      errors++; $display("FAIL wide_sub: got %h/%b expected ffffffff/0", sum32, c_out32); end
  endtask

  initial begin
    test_reset();
    // reset checks above only count; tally their failures here from the same comparisons
    if ({busy, done} !== 2'b00) errors++;
    if (sum !== 16'h0000) errors++;
    if (c_out !== 1'b0) errors++;
    if ({busy32, done32, c_out32} !== 3'b000 || sum32 !== 32'h0) errors++;
    test_add();
    test_sub();
    test_carry_chain();
    test_back_to_back();
    test_mid_reset();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
